// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage: icodes, ALU functions,
// condition codes, CC bit layout and the jXX/cmovXX condition evaluator.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;
  localparam logic [3:0] ALU_MUL = 4'h4;

  localparam logic [3:0] C_ALL = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam int CC_ZF = 0;
  localparam int CC_SF = 1;
  localparam int CC_OF = 2;
  localparam logic [2:0] CC_RESET = 3'b001;
  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} mul_state_e;

  function automatic logic cond_eval(input logic [2:0] cc, input logic [3:0] ifun);
    logic lt;
    lt = cc[CC_SF] ^ cc[CC_OF];
    case (ifun)
      C_ALL:   cond_eval = 1'b1;
      C_LE:    cond_eval = lt | cc[CC_ZF];
      C_L:     cond_eval = lt;
      C_E:     cond_eval = cc[CC_ZF];
      C_NE:    cond_eval = ~cc[CC_ZF];
      C_GE:    cond_eval = ~lt;
      C_G:     cond_eval = ~lt & ~cc[CC_ZF];
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exec_alu_core.sv
// Combinational Y86 ALU: ADD/SUB(b-a)/AND/XOR with ZF/SF/OF flags.
module exec_alu_core
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [3:0]       alufun,
  output logic [WIDTH-1:0] res,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  logic sa, sb, sr;

  always_comb begin
    res = '0;
    case (alufun)
      ALU_ADD: res = alu_b + alu_a;
      ALU_SUB: res = alu_b - alu_a;
      ALU_AND: res = alu_b & alu_a;
      ALU_XOR: res = alu_b ^ alu_a;
      default: res = '0;
    endcase
    sa = alu_a[WIDTH-1];
    sb = alu_b[WIDTH-1];
    sr = res[WIDTH-1];
    zf = (res == '0);
    sf = sr;
    case (alufun)
      ALU_ADD: of = (sa == sb) && (sr != sa);
      ALU_SUB: of = (sa != sb) && (sr != sb);
      default: of = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_pipe.sv
// Pipelined Y86-64 execute stage with valid/ready on both sides and a
// registered CC file. Optional iterative multiply under EXEC_MUL_EN.
module execute_pipe
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_icode,
  input  logic [3:0]       in_ifun,
  input  logic [WIDTH-1:0] in_valC,
  input  logic [WIDTH-1:0] in_valA,
  input  logic [WIDTH-1:0] in_valB,
  input  logic [3:0]       in_dstE,
  input  logic             flush,
  input  logic             cc_inhibit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_icode,
  output logic [WIDTH-1:0] out_valE,
  output logic [WIDTH-1:0] out_valA,
  output logic [3:0]       out_dstE,
  output logic             out_cnd,
  output logic             out_err,
  output logic [2:0]       cc,
  output logic             busy
);

`ifdef EXEC_MUL_EN
  localparam logic [3:0] OP_MAX = ALU_MUL;
`else
  localparam logic [3:0] OP_MAX = ALU_XOR;
`endif

  logic [WIDTH-1:0] alu_a, alu_b, alu_res;
  logic [3:0]       alufun;
  logic             alu_zf, alu_sf, alu_of;
  logic             is_op, op_err, take_cnd, accept, is_mul;

  logic             out_valid_q, out_valid_d;
  logic [3:0]       out_icode_q, out_icode_d;
  logic [WIDTH-1:0] out_vale_q, out_vale_d;
  logic [WIDTH-1:0] out_vala_q, out_vala_d;
  logic [3:0]       out_dste_q, out_dste_d;
  logic             out_cnd_q, out_cnd_d;
  logic             out_err_q, out_err_d;
  logic [2:0]       cc_q, cc_d;

  always_comb begin
    alu_a = '0;
    case (in_icode)
      I_RRMOVQ, I_OPQ:              alu_a = in_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = in_valC;
      I_CALL, I_PUSHQ:              alu_a = {WIDTH{1'b0}} - WIDTH'(8);
      I_RET, I_POPQ:                alu_a = WIDTH'(8);
      default:                      alu_a = '0;
    endcase
    alu_b = '0;
    case (in_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = in_valB;
      default: alu_b = '0;
    endcase
    alufun = (in_icode == I_OPQ) ? in_ifun : ALU_ADD;
  end

  exec_alu_core #(.WIDTH(WIDTH)) u_alu (
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alufun (alufun),
    .res    (alu_res),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of)
  );

  always_comb begin
    is_op    = (in_icode == I_OPQ);
    op_err   = is_op && (in_ifun > OP_MAX);
    // Conditions always read the CC state from before this op's own update.
    take_cnd = (in_icode == I_JXX || in_icode == I_RRMOVQ) ? cond_eval(cc_q, in_ifun) : 1'b0;
    accept   = in_valid && in_ready && !flush;
  end

`ifdef EXEC_MUL_EN
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mul_state_e       state_q, state_d;
  logic [CW-1:0]    mul_cnt_q, mul_cnt_d;
  logic [WIDTH-1:0] mul_acc_q, mul_acc_d;
  logic [WIDTH-1:0] mul_mcand_q, mul_mcand_d;
  logic [WIDTH-1:0] mul_mplier_q, mul_mplier_d;
  logic [WIDTH-1:0] mul_vala_q, mul_vala_d;
  logic [3:0]       mul_dste_q, mul_dste_d;
  logic             mul_done, mul_stall;

  assign is_mul = is_op && (in_ifun == ALU_MUL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mul_cnt_q    <= '0;
      mul_acc_q    <= '0;
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
      mul_vala_q   <= '0;
      mul_dste_q   <= REG_NONE;
    end else begin
      state_q      <= state_d;
      mul_cnt_q    <= mul_cnt_d;
      mul_acc_q    <= mul_acc_d;
      mul_mcand_q  <= mul_mcand_d;
      mul_mplier_q <= mul_mplier_d;
      mul_vala_q   <= mul_vala_d;
      mul_dste_q   <= mul_dste_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mul) state_d = S_BUSY;
      S_BUSY:  if (flush || mul_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_BUSY);
    mul_stall = out_valid_q && !out_ready;
    mul_done  = busy && (mul_cnt_q == '0) && !mul_stall;
  end

  // One shift-add step per BUSY cycle; the last step is held while the
  // output register is still occupied so the product is never lost.
  always_comb begin
    mul_cnt_d    = mul_cnt_q;
    mul_acc_d    = mul_acc_q;
    mul_mcand_d  = mul_mcand_q;
    mul_mplier_d = mul_mplier_q;
    mul_vala_d   = mul_vala_q;
    mul_dste_d   = mul_dste_q;
    if (accept && is_mul) begin
      mul_cnt_d    = CW'(WIDTH - 1);
      mul_acc_d    = '0;
      mul_mcand_d  = in_valA;
      mul_mplier_d = in_valB;
      mul_vala_d   = in_valA;
      mul_dste_d   = in_dstE;
    end else if (busy && !(mul_cnt_q == '0 && mul_stall)) begin
      mul_acc_d    = mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : '0);
      mul_mcand_d  = mul_mcand_q << 1;
      mul_mplier_d = mul_mplier_q >> 1;
      if (mul_cnt_q != '0) mul_cnt_d = mul_cnt_q - 1'b1;
    end
  end

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
`else
  assign is_mul   = 1'b0;
  assign busy     = 1'b0;
  assign in_ready = !out_valid_q || out_ready;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_icode_d = out_icode_q;
    out_vale_d  = out_vale_q;
    out_vala_d  = out_vala_q;
    out_dste_d  = out_dste_q;
    out_cnd_d   = out_cnd_q;
    out_err_d   = out_err_q;
    cc_d        = cc_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept && !is_mul) begin
      out_valid_d = 1'b1;
      out_icode_d = in_icode;
      out_vale_d  = op_err ? '0 : alu_res;
      out_vala_d  = in_valA;
      out_dste_d  = (in_icode == I_RRMOVQ && !take_cnd) ? REG_NONE : in_dstE;
      out_cnd_d   = take_cnd;
      out_err_d   = op_err;
      if (is_op && !op_err && !cc_inhibit) cc_d = {alu_of, alu_sf, alu_zf};
`ifdef EXEC_MUL_EN
    end else if (mul_done) begin
      out_valid_d = 1'b1;
      out_icode_d = I_OPQ;
      out_vale_d  = mul_acc_d;
      out_vala_d  = mul_vala_q;
      out_dste_d  = mul_dste_q;
      out_cnd_d   = 1'b0;
      out_err_d   = 1'b0;
      if (!cc_inhibit) cc_d = {1'b0, mul_acc_d[WIDTH-1], (mul_acc_d == '0)};
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_icode_q <= '0;
      out_vale_q  <= '0;
      out_vala_q  <= '0;
      out_dste_q  <= REG_NONE;
      out_cnd_q   <= 1'b0;
      out_err_q   <= 1'b0;
      cc_q        <= CC_RESET;
    end else begin
      out_valid_q <= out_valid_d;
      out_icode_q <= out_icode_d;
      out_vale_q  <= out_vale_d;
      out_vala_q  <= out_vala_d;
      out_dste_q  <= out_dste_d;
      out_cnd_q   <= out_cnd_d;
      out_err_q   <= out_err_d;
      cc_q        <= cc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_icode = out_icode_q;
  assign out_valE  = out_vale_q;
  assign out_valA  = out_vala_q;
  assign out_dstE  = out_dste_q;
  assign out_cnd   = out_cnd_q;
  assign out_err   = out_err_q;
  assign cc        = cc_q;

endmodule
